axis_fifo: RTL and testbench

Single-clock AXI-stream FIFO with an input width multiplexer. Each accepted input beat carries IN_MUX words, which are pushed in one cycle. The output side pops them one word per beat, lowest slice first. It sits behind producers such as the demapper, where one IQ sample yields two LLRs, and serializes their output into a narrow word stream.

---
 rtl/axis_fifo_if.sv | 15 +
 rtl/axis_fifo.sv | 79 +++++++
 tb/tb_axis_fifo.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_fifo_if.sv
// AXI-stream bundle shared by both sides of axis_fifo.
// The input side is IN_MUX words wide, so each side gets its own parameterisation.
interface axis_fifo_if #(
  parameter int DATA_W = 16,
  parameter int USER_W = 1
);
  logic [DATA_W-1:0] tdata;
  logic [USER_W-1:0] tuser;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, tuser, tlast, tvalid, input tready);
  modport slave  (input tdata, tuser, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_fifo.sv
// Single-clock AXI-stream FIFO: pushes IN_MUX words per accepted input beat,
// pops one word per output beat (lowest slice first), show-ahead read.
module axis_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_LEN   = 1024,
  parameter int USER_WIDTH = 1,
  parameter int ASYNC      = 0,
  parameter int IN_MUX     = 1
) (
  input  logic         clk_i,
  input  logic         reset_ni,
  axis_fifo_if.slave   s_axis_in,
  axis_fifo_if.master  m_axis_out
);

  localparam int AW = (FIFO_LEN > 1) ? $clog2(FIFO_LEN) : 1;
  localparam int CW = $clog2(FIFO_LEN + 1);
  localparam int EW = DATA_WIDTH + USER_WIDTH + 1;

  if (ASYNC != 0) begin : g_async_check
    $error("axis_fifo: ASYNC=%0d is not supported, only 0", ASYNC);
  end
  if (IN_MUX < 1) begin : g_mux_check
    $error("axis_fifo: IN_MUX must be at least 1");
  end
  if ((FIFO_LEN < 2) || ((FIFO_LEN & (FIFO_LEN - 1)) != 0) || ((FIFO_LEN % IN_MUX) != 0)) begin : g_len_check
    $error("axis_fifo: FIFO_LEN=%0d must be a power of two >= 2 and a multiple of IN_MUX", FIFO_LEN);
  end

  logic [EW-1:0] mem [FIFO_LEN];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic [CW-1:0] free_words;
  logic [EW-1:0] head;
  logic          wr_en;
  logic          rd_en;

  // Space check uses the current count only; a same-cycle pop is not credited.
  assign free_words      = CW'(FIFO_LEN) - count;
  assign s_axis_in.tready = (free_words >= CW'(IN_MUX));

  assign wr_en = s_axis_in.tvalid && s_axis_in.tready && !reset_ni;
  assign rd_en = m_axis_out.tvalid && m_axis_out.tready;

  assign head              = mem[rptr];
  assign m_axis_out.tdata  = head[DATA_WIDTH-1:0];
  assign m_axis_out.tuser  = head[DATA_WIDTH +: USER_WIDTH];
  assign m_axis_out.tlast  = head[EW-1];
  assign m_axis_out.tvalid = (count != '0);

  always_ff @(posedge clk_i or posedge reset_ni) begin
    if (reset_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + AW'(IN_MUX);
      end
      if (rd_en) begin
        rptr <= rptr + AW'(1);
      end
      count <= count + (wr_en ? CW'(IN_MUX) : CW'(0)) - (rd_en ? CW'(1) : CW'(0));
    end
  end

  // Only the last slice of a beat can carry the packet-end flag.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int i = 0; i < IN_MUX; i++) begin
        mem[wptr + AW'(i)] <= {((i == IN_MUX - 1) ? s_axis_in.tlast : 1'b0),
                               s_axis_in.tuser[i*USER_WIDTH +: USER_WIDTH],
                               s_axis_in.tdata[i*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
  end

endmodule

// File: tb/tb_axis_fifo.sv
// Directed bench for axis_fifo: a 2-word-mux instance (A) and a 1-word instance (B),
// both with FIFO_LEN=8 so the full/wrap boundaries are reachable quickly.
module tb_axis_fifo;

  logic clk_i;
  logic reset_ni;
  int   total;
  int   bad;

  axis_fifo_if #(.DATA_W(16), .USER_W(4)) a_in ();
  axis_fifo_if #(.DATA_W(8),  .USER_W(2)) a_out ();
  axis_fifo_if #(.DATA_W(8),  .USER_W(1)) b_in ();
  axis_fifo_if #(.DATA_W(8),  .USER_W(1)) b_out ();

  axis_fifo #(
    .DATA_WIDTH(8), .FIFO_LEN(8), .USER_WIDTH(2), .ASYNC(0), .IN_MUX(2)
  ) dut_a (
    .clk_i(clk_i), .reset_ni(reset_ni), .s_axis_in(a_in), .m_axis_out(a_out)
  );

  axis_fifo #(
    .DATA_WIDTH(8), .FIFO_LEN(8), .USER_WIDTH(1), .ASYNC(0), .IN_MUX(1)
  ) dut_b (
    .clk_i(clk_i), .reset_ni(reset_ni), .s_axis_in(b_in), .m_axis_out(b_out)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic idle_inputs();
    a_in.tvalid = 1'b0; a_in.tdata = '0; a_in.tuser = '0; a_in.tlast = 1'b0;
    a_out.tready = 1'b0;
    b_in.tvalid = 1'b0; b_in.tdata = '0; b_in.tuser = '0; b_in.tlast = 1'b0;
    b_out.tready = 1'b0;
  endtask

  task automatic test_reset();
    reset_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    total++;
    if (a_out.tvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_a_tvalid got=%0b want=0", a_out.tvalid); end
    total++;
    if (a_in.tready !== 1'b1) begin bad++; $display("[TB] FAIL reset_a_tready got=%0b want=1", a_in.tready); end
    total++;
    if (b_out.tvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_b_tvalid got=%0b want=0", b_out.tvalid); end
    total++;
    if (b_in.tready !== 1'b1) begin bad++; $display("[TB] FAIL reset_b_tready got=%0b want=1", b_in.tready); end
    reset_ni = 1'b0;
    @(posedge clk_i);
  endtask

  task automatic test_mux_order();
    logic [7:0] exp_data [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic       exp_last [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      a_out.tready = 1'b1;
      a_in.tuser   = 4'b0101;
      if (c == 0) begin
        a_in.tvalid = 1'b1; a_in.tdata = 16'hB2A1; a_in.tlast = 1'b0;
      end else if (c == 1) begin
        a_in.tvalid = 1'b1; a_in.tdata = 16'hD4C3; a_in.tlast = 1'b1;
      end else begin
        a_in.tvalid = 1'b0; a_in.tlast = 1'b0;
      end
      total++;
      if (a_out.tvalid !== ((c >= 1) && (c <= 4))) begin
        bad++; $display("[TB] FAIL mux_tvalid c=%0d got=%0b want=%0b", c, a_out.tvalid, ((c >= 1) && (c <= 4)));
      end
      if ((c >= 1) && (c <= 4)) begin
        total++;
        if (a_out.tdata !== exp_data[c-1]) begin
          bad++; $display("[TB] FAIL mux_tdata c=%0d got=%h want=%h", c, a_out.tdata, exp_data[c-1]);
        end
        total++;
        if (a_out.tlast !== exp_last[c-1]) begin
          bad++; $display("[TB] FAIL mux_tlast c=%0d got=%0b want=%0b", c, a_out.tlast, exp_last[c-1]);
        end
        total++;
        if (a_out.tuser !== 2'b01) begin
          bad++; $display("[TB] FAIL mux_tuser c=%0d got=%b want=01", c, a_out.tuser);
        end
      end
      @(posedge clk_i);
    end
    @(negedge clk_i);
    idle_inputs();
  endtask

  task automatic test_fill();
    logic [7:0] lo;
    logic [7:0] hi;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      a_out.tready = 1'b0;
      lo = 8'(16 + 2 * k);
      hi = 8'(17 + 2 * k);
      a_in.tvalid = 1'b1; a_in.tdata = {hi, lo}; a_in.tlast = 1'b0; a_in.tuser = '0;
      total++;
      if (a_in.tready !== (k < 4)) begin
        bad++; $display("[TB] FAIL fill_tready beat=%0d got=%0b want=%0b", k, a_in.tready, (k < 4));
      end
      @(posedge clk_i);
    end
    // Drain: tready stays low until free space is back to two words.
    for (int w = 0; w < 9; w++) begin
      @(negedge clk_i);
      a_in.tvalid  = 1'b0;
      a_out.tready = 1'b1;
      total++;
      if (a_in.tready !== (w >= 2)) begin
        bad++; $display("[TB] FAIL fill_drain_tready w=%0d got=%0b want=%0b", w, a_in.tready, (w >= 2));
      end
      total++;
      if (a_out.tvalid !== (w < 8)) begin
        bad++; $display("[TB] FAIL fill_drain_tvalid w=%0d got=%0b want=%0b", w, a_out.tvalid, (w < 8));
      end
      if (w < 8) begin
        total++;
        if (a_out.tdata !== 8'(16 + w)) begin
          bad++; $display("[TB] FAIL fill_drain_tdata w=%0d got=%h want=%h", w, a_out.tdata, 8'(16 + w));
        end
      end
      @(posedge clk_i);
    end
    @(negedge clk_i);
    idle_inputs();
  endtask

  task automatic test_reset_mid_stream();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      a_out.tready = 1'b0;
      a_in.tvalid = 1'b1; a_in.tdata = {8'(49 + 2 * k), 8'(48 + 2 * k)}; a_in.tlast = 1'b0;
      @(posedge clk_i);
    end
    a_in.tdata = 16'hEEEE;
    #2;
    reset_ni = 1'b1;
    #1;
    total++;
    if (a_out.tvalid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_tvalid got=%0b want=0", a_out.tvalid); end
    total++;
    if (a_in.tready !== 1'b1) begin bad++; $display("[TB] FAIL midreset_tready got=%0b want=1", a_in.tready); end
    @(posedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b0;
    a_in.tvalid = 1'b0;
    total++;
    if (a_out.tvalid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_write_ignored got=%0b want=0", a_out.tvalid); end
    @(posedge clk_i);
    @(negedge clk_i);
    a_in.tvalid = 1'b1; a_in.tdata = 16'h5B5A; a_out.tready = 1'b1;
    @(posedge clk_i);
    for (int w = 0; w < 3; w++) begin
      @(negedge clk_i);
      a_in.tvalid = 1'b0;
      total++;
      if (a_out.tvalid !== (w < 2)) begin
        bad++; $display("[TB] FAIL midreset_post_tvalid w=%0d got=%0b want=%0b", w, a_out.tvalid, (w < 2));
      end
      if (w < 2) begin
        total++;
        if (a_out.tdata !== 8'(8'h5A + w)) begin
          bad++; $display("[TB] FAIL midreset_post_tdata w=%0d got=%h want=%h", w, a_out.tdata, 8'(8'h5A + w));
        end
      end
      @(posedge clk_i);
    end
    @(negedge clk_i);
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_i);
      b_out.tready = 1'b0;
      b_in.tvalid = 1'b1; b_in.tdata = 8'(32 + i);
      total++;
      if (b_in.tready !== 1'b1) begin bad++; $display("[TB] FAIL sim_fill_tready i=%0d got=%0b want=1", i, b_in.tready); end
      @(posedge clk_i);
    end
    // Count is 7 here: push 0x27 and pop 0x20 on the same edge.
    @(negedge clk_i);
    b_in.tvalid = 1'b1; b_in.tdata = 8'h27; b_out.tready = 1'b1;
    total++;
    if (b_in.tready !== 1'b1) begin bad++; $display("[TB] FAIL sim_tready_at7 got=%0b want=1", b_in.tready); end
    total++;
    if (b_out.tdata !== 8'h20) begin bad++; $display("[TB] FAIL sim_head got=%h want=20", b_out.tdata); end
    @(posedge clk_i);
    for (int w = 0; w < 8; w++) begin
      @(negedge clk_i);
      b_in.tvalid  = 1'b0;
      b_out.tready = 1'b1;
      if (w == 0) begin
        total++;
        if (b_in.tready !== 1'b1) begin bad++; $display("[TB] FAIL sim_count_stays7 tready got=%0b want=1", b_in.tready); end
      end
      total++;
      if (b_out.tvalid !== (w < 7)) begin
        bad++; $display("[TB] FAIL sim_drain_tvalid w=%0d got=%0b want=%0b", w, b_out.tvalid, (w < 7));
      end
      if (w < 7) begin
        total++;
        if (b_out.tdata !== 8'(33 + w)) begin
          bad++; $display("[TB] FAIL sim_drain_tdata w=%0d got=%h want=%h", w, b_out.tdata, 8'(33 + w));
        end
      end
      @(posedge clk_i);
    end
    @(negedge clk_i);
    idle_inputs();
  endtask

  task automatic test_wrap();
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    while ((got < 40) && (cyc < 400)) begin
      @(negedge clk_i);
      b_in.tvalid  = (sent < 40);
      b_in.tdata   = 8'(sent);
      b_out.tready = 1'($urandom_range(0, 1));
      if (b_in.tvalid && b_in.tready) sent++;
      if (b_out.tvalid && b_out.tready) begin
        total++;
        if (b_out.tdata !== 8'(got)) begin
          bad++; $display("[TB] FAIL wrap_tdata idx=%0d got=%h want=%h", got, b_out.tdata, 8'(got));
        end
        got++;
      end
      @(posedge clk_i);
      cyc++;
    end
    total++;
    if (got != 40) begin bad++; $display("[TB] FAIL wrap_timeout words got=%0d want=40", got); end
    @(negedge clk_i);
    idle_inputs();
    total++;
    if (b_out.tvalid !== 1'b0) begin bad++; $display("[TB] FAIL wrap_empty tvalid got=%0b want=0", b_out.tvalid); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    reset_ni = 1'b1;
    test_reset();
    test_mux_order();
    test_fill();
    test_reset_mid_stream();
    test_simultaneous();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
